tlp_fifo_drain: RTL and testbench

TLP_FIFO_DRAIN -- requirements
Module: tlp_fifo_drain

---
 rtl/tlp_fifo_drain_pkg.sv | 32 +++
 rtl/tlp_fifo_drain_if.sv | 27 ++
 rtl/tlp_skid_buf2.sv | 52 +++++
 rtl/tlp_fifo_drain.sv | 123 ++++++++++++
 tb/tb_tlp_fifo_drain.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlp_fifo_drain_pkg.sv
// tlp_fifo_drain_pkg: shared definitions for the TLP FIFO drain block.
//   - FIFO entry layout (267 bits): [266] sop, [265] eop, [264] err,
//     [263:256] keep, [255:0] data
//   - FSM state enum; ST_DROP exists only with TLP_FIFO_DRAIN_ERR_DROP_EN
package tlp_fifo_drain_pkg;

  localparam int ENTRY_W = 267;
  localparam int DATA_W  = 256;
  localparam int SOP_BIT = 266;
  localparam int EOP_BIT = 265;
  localparam int ERR_BIT = 264;
  localparam int KEEP_HI = 263;
  localparam int KEEP_LO = 256;

  // Field order matches the bit positions above (sop is the MSB).
  typedef struct packed {
    logic         sop;
    logic         eop;
    logic         err;
    logic [7:0]   keep;
    logic [255:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1
`ifdef TLP_FIFO_DRAIN_ERR_DROP_EN
    , ST_DROP = 2'd2
`endif
  } state_t;

endpackage

// File: rtl/tlp_fifo_drain_if.sv
// tlp_fifo_drain_if: FIFO-side and transmit-side signals of the drain.
//   master : the drain (reads FIFO head, pops, drives tx beat)
//   slave  : the FIFO / downstream sink
interface tlp_fifo_drain_if #(parameter int KEEP_W = 8);
  import tlp_fifo_drain_pkg::*;

  logic [ENTRY_W-1:0] fifoDataOut;
  logic               fifoEmpty;
  logic               fifoPop;
  logic               txValid;
  logic               txReady;
  logic [DATA_W-1:0]  txData;
  logic [KEEP_W-1:0]  txKeep;
  logic               txSop;
  logic               txEop;
  logic               txErr;

  modport master (
    input  fifoDataOut, fifoEmpty, txReady,
    output fifoPop, txValid, txData, txKeep, txSop, txEop, txErr
  );

  modport slave (
    output fifoDataOut, fifoEmpty, txReady,
    input  fifoPop, txValid, txData, txKeep, txSop, txEop, txErr
  );
endinterface

// File: rtl/tlp_skid_buf2.sv
// tlp_skid_buf2: 2-entry output register with valid/ready handshake.
//   in_valid/in_data : push (caller must not push when occ==2 unless the
//                      head is handed off in the same cycle)
//   out_valid/out_ready/out_data : downstream handshake, head entry
//   occ              : occupancy 0..2
module tlp_skid_buf2
  import tlp_fifo_drain_pkg::*;
#(
  parameter int W = ENTRY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occ
);

  logic [W-1:0] head, tail;
  logic         pop;

  assign out_valid = (occ != 2'd0);
  assign out_data  = head;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      case ({in_valid, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: ;
      endcase
      // head: refill from tail when it holds the next beat, else from input
      if (pop) begin
        if (occ == 2'd2)   head <= tail;
        else if (in_valid) head <= in_data;
      end else if (in_valid && occ == 2'd0) begin
        head <= in_data;
      end
      // tail only ever holds the second-oldest beat
      if (in_valid && ((occ == 2'd1 && !pop) || occ == 2'd2))
        tail <= in_data;
    end
  end

endmodule

// File: rtl/tlp_fifo_drain.sv
// tlp_fifo_drain: drains a show-ahead FIFO of TLP beats onto a valid/ready
// stream, enforcing sop/eop framing.
//   clockCore, resetCore : clock, async active-high reset
//   bus (master)         : FIFO head/empty/pop and tx beat handshake
//   framingError         : sticky framing violation, cleared by clearError
//   pktCount, dropCount  : wrapping counters of sent eops / discarded beats
//   busy                 : FSM not idle or output buffer non-empty
// Optional feature: TLP_FIFO_DRAIN_ERR_DROP_EN truncates a packet at an
// err beat and discards the rest of it.
module tlp_fifo_drain
  import tlp_fifo_drain_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int KEEP_W = 8
) (
  input  logic                  clockCore,
  input  logic                  resetCore,
  tlp_fifo_drain_if.master      bus,
  output logic                  framingError,
  input  logic                  clearError,
  output logic [CNT_W-1:0]      pktCount,
  output logic [CNT_W-1:0]      dropCount,
  output logic                  busy
);

  state_t             state, state_nxt;
  entry_t             head, fwd_beat;
  logic               fwd, fe_set, drop_inc;
  logic [1:0]         occ;
  logic [ENTRY_W-1:0] out_q;

  assign head = entry_t'(bus.fifoDataOut);

  // Pop whenever the buffer can take the beat this edge; gated by reset so
  // it drops immediately on assertion.
  assign bus.fifoPop = !resetCore && !bus.fifoEmpty &&
                       !(occ == 2'd2 && !bus.txReady);

  always_ff @(posedge clockCore or posedge resetCore) begin
    if (resetCore) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fwd       = 1'b0;
    fe_set    = 1'b0;
    drop_inc  = 1'b0;
    fwd_beat  = head;
    if (bus.fifoPop) begin
      case (state)
        ST_IDLE: begin
          if (!head.sop) begin
            fe_set   = 1'b1;
            drop_inc = 1'b1;
          end else begin
            fwd = 1'b1;
            if (!head.eop) state_nxt = ST_PKT;
          end
        end
        ST_PKT: begin
          if (head.sop) begin
            // restart: treat as a new packet start
            fe_set = 1'b1;
            fwd    = 1'b1;
            if (head.eop) state_nxt = ST_IDLE;
`ifdef TLP_FIFO_DRAIN_ERR_DROP_EN
          end else if (head.err && !head.eop) begin
            // close the packet on the err beat; an err beat that already
            // carries eop simply ends the packet, so nothing follows to drop
            fwd          = 1'b1;
            fwd_beat.eop = 1'b1;
            state_nxt    = ST_DROP;
`endif
          end else begin
            fwd = 1'b1;
            if (head.eop) state_nxt = ST_IDLE;
          end
        end
`ifdef TLP_FIFO_DRAIN_ERR_DROP_EN
        ST_DROP: begin
          drop_inc = 1'b1;
          if (head.eop) state_nxt = ST_IDLE;
        end
`endif
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  tlp_skid_buf2 #(.W(ENTRY_W)) u_skid (
    .clk       (clockCore),
    .rst       (resetCore),
    .in_valid  (fwd),
    .in_data   (fwd_beat),
    .out_valid (bus.txValid),
    .out_ready (bus.txReady),
    .out_data  (out_q),
    .occ       (occ)
  );

  assign bus.txSop  = out_q[SOP_BIT];
  assign bus.txEop  = out_q[EOP_BIT];
  assign bus.txErr  = out_q[ERR_BIT];
  assign bus.txKeep = out_q[KEEP_LO +: KEEP_W];
  assign bus.txData = out_q[DATA_W-1:0];

  assign busy = (state != ST_IDLE) || (occ != 2'd0);

  always_ff @(posedge clockCore or posedge resetCore) begin
    if (resetCore) begin
      framingError <= 1'b0;
      pktCount     <= '0;
      dropCount    <= '0;
    end else begin
      if (fe_set)          framingError <= 1'b1;
      else if (clearError) framingError <= 1'b0;
      if (bus.txValid && bus.txReady && bus.txEop) pktCount <= pktCount + CNT_W'(1);
      if (drop_inc) dropCount <= dropCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_tlp_fifo_drain.sv
// tb_tlp_fifo_drain: directed bench for tlp_fifo_drain with a show-ahead
// FIFO model and an output beat monitor.
module tb_tlp_fifo_drain;
  import tlp_fifo_drain_pkg::*;

  localparam int CNT_W = 16;

  logic             clockCore = 1'b0;
  logic             resetCore = 1'b0;
  logic             clearError = 1'b0;
  logic             framingError, busy;
  logic [CNT_W-1:0] pktCount, dropCount;

  tlp_fifo_drain_if #(.KEEP_W(8)) bus ();

  tlp_fifo_drain #(.CNT_W(CNT_W), .KEEP_W(8)) dut (
    .clockCore    (clockCore),
    .resetCore    (resetCore),
    .bus          (bus),
    .framingError (framingError),
    .clearError   (clearError),
    .pktCount     (pktCount),
    .dropCount    (dropCount),
    .busy         (busy)
  );

  always #5 clockCore = ~clockCore;

  // show-ahead FIFO model
  logic [ENTRY_W-1:0] mem [64];
  int rd = 0;
  int wr = 0;
  assign bus.fifoEmpty   = (rd == wr);
  assign bus.fifoDataOut = mem[rd & 63];
  always @(posedge clockCore) if (bus.fifoPop) rd <= rd + 1;

  int nchk = 0;
  int nfail = 0;
  int cyc_n = 0;
  logic [ENTRY_W-1:0] obeat [$];
  int ocyc [$];
  int pop_log [$];

  function automatic logic [ENTRY_W-1:0] mk(input logic s, input logic e,
                                             input logic r, input logic [7:0] tag);
    mk = {s, e, r, tag, {8{24'hC0FFEE, tag}}};
  endfunction

  function automatic logic [ENTRY_W-1:0] cur_beat();
    cur_beat = {bus.txSop, bus.txEop, bus.txErr, bus.txKeep, bus.txData};
  endfunction

  // monitor: samples mid-cycle, logs pops and completed handshakes
  always @(negedge clockCore) begin
    cyc_n <= cyc_n + 1;
    if (!resetCore) begin
      nchk++;
      if (bus.fifoPop && bus.fifoEmpty) begin
        nfail++;
        $display("FAIL pop_on_empty: fifoPop=1 while fifoEmpty=1 at cycle %0d", cyc_n);
      end
      if (bus.fifoPop) pop_log.push_back(cyc_n);
      if (bus.txValid && bus.txReady) begin
        obeat.push_back(cur_beat());
        ocyc.push_back(cyc_n);
      end
    end
  end

  task automatic push(input logic [ENTRY_W-1:0] e);
    mem[wr & 63] = e;
    wr = wr + 1;
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 60 && obeat.size() < n; i++) @(negedge clockCore);
    repeat (5) @(negedge clockCore);
  endtask

  task automatic clear_logs();
    obeat.delete(); ocyc.delete(); pop_log.delete();
  endtask

  task automatic test_reset();
    bus.txReady = 1'b1;
    #1 resetCore = 1'b1;
    push(mk(1, 1, 0, 8'h01));   // non-empty FIFO must still see no pop
    #1;
    nchk++; if (bus.fifoPop !== 1'b0) begin nfail++; $display("FAIL reset_fifoPop: got %b want 0", bus.fifoPop); end
    nchk++; if (bus.txValid !== 1'b0) begin nfail++; $display("FAIL reset_txValid: got %b want 0", bus.txValid); end
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b want 0", busy); end
    nchk++; if (framingError !== 1'b0) begin nfail++; $display("FAIL reset_framingError: got %b want 0", framingError); end
    nchk++; if (pktCount !== 16'd0 || dropCount !== 16'd0) begin nfail++; $display("FAIL reset_counts: got pkt=%0d drop=%0d want 0/0", pktCount, dropCount); end
    nchk++; if (cur_beat() !== '0) begin nfail++; $display("FAIL reset_txfields: got %h want 0", cur_beat()); end
    wr = rd;
    repeat (3) @(posedge clockCore);
    #1 resetCore = 1'b0;
    @(posedge clockCore); #1;
  endtask

  task automatic test_basic();
    logic [ENTRY_W-1:0] exp [4];
    clear_logs();
    exp[0] = mk(1, 0, 0, 8'h10); exp[1] = mk(0, 0, 0, 8'h11);
    exp[2] = mk(0, 0, 0, 8'h12); exp[3] = mk(0, 1, 0, 8'h13);
    bus.txReady = 1'b1;
    for (int i = 0; i < 4; i++) push(exp[i]);
    wait_beats(4);
    nchk++; if (obeat.size() !== 4) begin nfail++; $display("FAIL basic_count: got %0d beats want 4", obeat.size()); end
    for (int i = 0; i < 4 && i < obeat.size(); i++) begin
      nchk++; if (obeat[i] !== exp[i]) begin nfail++; $display("FAIL basic_beat%0d: got %h want %h", i, obeat[i], exp[i]); end
      nchk++; if (ocyc[i] !== ocyc[0] + i) begin nfail++; $display("FAIL basic_cycle%0d: got %0d want %0d", i, ocyc[i], ocyc[0] + i); end
    end
    if (obeat.size() > 0 && pop_log.size() > 0) begin
      nchk++; if (ocyc[0] - pop_log[0] !== 1) begin nfail++; $display("FAIL basic_latency: got %0d want 1", ocyc[0] - pop_log[0]); end
    end
    nchk++; if (pktCount !== 16'd1) begin nfail++; $display("FAIL basic_pktCount: got %0d want 1", pktCount); end
  endtask

  task automatic test_stall();
    logic [ENTRY_W-1:0] exp [4];
    logic [ENTRY_W-1:0] held;
    logic stalled;
    int occ_m, n_full;
    clear_logs();
    exp[0] = mk(1, 0, 0, 8'h20); exp[1] = mk(0, 0, 0, 8'h21);
    exp[2] = mk(0, 0, 0, 8'h22); exp[3] = mk(0, 1, 0, 8'h23);
    occ_m = 0; n_full = 0; stalled = 1'b0; held = '0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clockCore); #1;
      bus.txReady = (i % 2 == 0);
      if (i == 0) for (int k = 0; k < 4; k++) push(exp[k]);
      @(negedge clockCore);
      nchk++; if (bus.txValid !== (occ_m != 0)) begin nfail++; $display("FAIL stall_txValid c%0d: got %b want %b", i, bus.txValid, occ_m != 0); end
      if (occ_m == 2 && !bus.txReady) begin
        n_full++;
        nchk++; if (bus.fifoPop !== 1'b0) begin nfail++; $display("FAIL stall_pop_full c%0d: got %b want 0", i, bus.fifoPop); end
      end
      if (stalled) begin
        nchk++; if (!bus.txValid || cur_beat() !== held) begin nfail++; $display("FAIL stall_hold c%0d: got %h want %h", i, cur_beat(), held); end
      end
      stalled = bus.txValid && !bus.txReady;
      held = cur_beat();
      occ_m = occ_m + int'(bus.fifoPop) - int'(bus.txValid && bus.txReady);
    end
    nchk++; if (n_full == 0) begin nfail++; $display("FAIL stall_occ2_reached: got 0 full-stall cycles want >0"); end
    nchk++; if (obeat.size() !== 4) begin nfail++; $display("FAIL stall_count: got %0d beats want 4", obeat.size()); end
    for (int i = 0; i < 4 && i < obeat.size(); i++) begin
      nchk++; if (obeat[i] !== exp[i]) begin nfail++; $display("FAIL stall_beat%0d: got %h want %h", i, obeat[i], exp[i]); end
    end
    nchk++; if (pktCount !== 16'd2) begin nfail++; $display("FAIL stall_pktCount: got %0d want 2", pktCount); end
  endtask

  task automatic test_no_sop();
    clear_logs();
    bus.txReady = 1'b1;
    push(mk(0, 1, 0, 8'h30));
    repeat (5) @(negedge clockCore);
    nchk++; if (obeat.size() !== 0) begin nfail++; $display("FAIL nosop_forwarded: got %0d beats want 0", obeat.size()); end
    nchk++; if (framingError !== 1'b1) begin nfail++; $display("FAIL nosop_framingError: got %b want 1", framingError); end
    nchk++; if (dropCount !== 16'd1) begin nfail++; $display("FAIL nosop_dropCount: got %0d want 1", dropCount); end
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL nosop_busy: got %b want 0", busy); end
    @(posedge clockCore); #1 clearError = 1'b1;
    @(posedge clockCore); #1 clearError = 1'b0;
    nchk++; if (framingError !== 1'b0) begin nfail++; $display("FAIL nosop_clear: got %b want 0", framingError); end
    // clear and a new violation on the same edge: set wins
    push(mk(0, 0, 0, 8'h31));
    clearError = 1'b1;
    @(posedge clockCore); #1 clearError = 1'b0;
    nchk++; if (framingError !== 1'b1) begin nfail++; $display("FAIL nosop_set_wins: got %b want 1", framingError); end
    nchk++; if (dropCount !== 16'd2) begin nfail++; $display("FAIL nosop_dropCount2: got %0d want 2", dropCount); end
    @(posedge clockCore); #1 clearError = 1'b1;
    @(posedge clockCore); #1 clearError = 1'b0;
  endtask

  task automatic test_sop_in_pkt();
    logic [ENTRY_W-1:0] exp [5];
    clear_logs();
    exp[0] = mk(1, 0, 0, 8'h A0 - 8'h00); exp[1] = mk(0, 0, 0, 8'hA1);
    exp[2] = mk(1, 0, 0, 8'hB0); exp[3] = mk(0, 0, 0, 8'hB1); exp[4] = mk(0, 1, 0, 8'hB2);
    bus.txReady = 1'b1;
    nchk++; if (framingError !== 1'b0) begin nfail++; $display("FAIL sopinpkt_pre: got %b want 0", framingError); end
    for (int i = 0; i < 5; i++) push(exp[i]);
    wait_beats(5);
    nchk++; if (obeat.size() !== 5) begin nfail++; $display("FAIL sopinpkt_count: got %0d beats want 5", obeat.size()); end
    for (int i = 0; i < 5 && i < obeat.size(); i++) begin
      nchk++; if (obeat[i] !== exp[i]) begin nfail++; $display("FAIL sopinpkt_beat%0d: got %h want %h", i, obeat[i], exp[i]); end
    end
    nchk++; if (framingError !== 1'b1) begin nfail++; $display("FAIL sopinpkt_framingError: got %b want 1", framingError); end
    nchk++; if (pktCount !== 16'd3) begin nfail++; $display("FAIL sopinpkt_pktCount: got %0d want 3", pktCount); end
    @(posedge clockCore); #1 clearError = 1'b1;
    @(posedge clockCore); #1 clearError = 1'b0;
  endtask

  task automatic test_err();
    logic [ENTRY_W-1:0] exp [$];
    int exp_drop;
    clear_logs();
    bus.txReady = 1'b1;
    push(mk(1, 0, 0, 8'h40)); push(mk(0, 0, 1, 8'h41)); push(mk(0, 0, 0, 8'h42));
    push(mk(0, 0, 0, 8'h43)); push(mk(0, 1, 0, 8'h44)); push(mk(1, 1, 0, 8'h45));
`ifdef TLP_FIFO_DRAIN_ERR_DROP_EN
    exp.push_back(mk(1, 0, 0, 8'h40)); exp.push_back(mk(0, 1, 1, 8'h41));
    exp_drop = 5;
`else
    exp.push_back(mk(1, 0, 0, 8'h40)); exp.push_back(mk(0, 0, 1, 8'h41));
    exp.push_back(mk(0, 0, 0, 8'h42)); exp.push_back(mk(0, 0, 0, 8'h43));
    exp.push_back(mk(0, 1, 0, 8'h44));
    exp_drop = 2;
`endif
    exp.push_back(mk(1, 1, 0, 8'h45));
    wait_beats(exp.size());
    nchk++; if (obeat.size() !== exp.size()) begin nfail++; $display("FAIL err_count: got %0d beats want %0d", obeat.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < obeat.size(); i++) begin
      nchk++; if (obeat[i] !== exp[i]) begin nfail++; $display("FAIL err_beat%0d: got %h want %h", i, obeat[i], exp[i]); end
    end
    nchk++; if (dropCount !== 16'(exp_drop)) begin nfail++; $display("FAIL err_dropCount: got %0d want %0d", dropCount, exp_drop); end
    nchk++; if (pktCount !== 16'd5) begin nfail++; $display("FAIL err_pktCount: got %0d want 5", pktCount); end
  endtask

  task automatic test_midreset();
    logic [ENTRY_W-1:0] n0, n1;
    clear_logs();
    bus.txReady = 1'b0;
    push(mk(1, 0, 0, 8'h50)); push(mk(0, 0, 0, 8'h51));
    push(mk(0, 0, 0, 8'h52)); push(mk(0, 1, 0, 8'h53));
    repeat (4) @(negedge clockCore);
    nchk++; if (bus.fifoPop !== 1'b0 || bus.txValid !== 1'b1 || busy !== 1'b1) begin nfail++; $display("FAIL midrst_pre: got pop=%b valid=%b busy=%b want 0/1/1", bus.fifoPop, bus.txValid, busy); end
    resetCore = 1'b1;
    #1;
    nchk++; if (bus.txValid !== 1'b0 || bus.fifoPop !== 1'b0 || busy !== 1'b0) begin nfail++; $display("FAIL midrst_ctl: got valid=%b pop=%b busy=%b want 0/0/0", bus.txValid, bus.fifoPop, busy); end
    nchk++; if (pktCount !== 16'd0 || dropCount !== 16'd0 || framingError !== 1'b0) begin nfail++; $display("FAIL midrst_stat: got pkt=%0d drop=%0d fe=%b want 0/0/0", pktCount, dropCount, framingError); end
    nchk++; if (cur_beat() !== '0) begin nfail++; $display("FAIL midrst_txfields: got %h want 0", cur_beat()); end
    wr = rd;
    repeat (2) @(posedge clockCore);
    #1 resetCore = 1'b0;
    clear_logs();
    n0 = mk(1, 0, 0, 8'h60); n1 = mk(0, 1, 0, 8'h61);
    @(posedge clockCore); #1;
    bus.txReady = 1'b1;
    push(n0); push(n1);
    wait_beats(2);
    nchk++; if (obeat.size() !== 2) begin nfail++; $display("FAIL midrst_count: got %0d beats want 2", obeat.size()); end
    if (obeat.size() >= 2) begin
      nchk++; if (obeat[0] !== n0) begin nfail++; $display("FAIL midrst_first: got %h want %h", obeat[0], n0); end
      nchk++; if (obeat[1] !== n1) begin nfail++; $display("FAIL midrst_second: got %h want %h", obeat[1], n1); end
    end
    nchk++; if (pktCount !== 16'd1) begin nfail++; $display("FAIL midrst_pktCount: got %0d want 1", pktCount); end
  endtask

  initial begin
    bus.txReady = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_no_sop();
    test_sop_in_pkt();
    test_err();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
